// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants for the rv32im pipeline stage registers
package rv_pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PIPE_PC_W = 32;
  localparam int PIPE_INSTR_W = 32;
  localparam int PIPE_TAG_W = 4;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
endpackage

// File: rtl/pipe_slot_reg.sv
// pipe_slot_reg: load-enabled PC/instr/tag register that resets to a NOP payload
module pipe_slot_reg #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int TAG_W = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
)(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic [PC_W-1:0]    pc_d,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [TAG_W-1:0]   tag_d,
  output logic [PC_W-1:0]    pc_q,
  output logic [INSTR_W-1:0] instr_q,
  output logic [TAG_W-1:0]   tag_q
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc_q <= '0;
      instr_q <= NOP_INSTR;
      tag_q <= '0;
    end else if (load) begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      tag_q <= tag_d;
    end
endmodule

// File: rtl/pipe_skid_stage_reg.sv
// pipe_skid_stage_reg: valid/ready pipeline stage register, optional two-entry skid buffer
module pipe_skid_stage_reg #(
  parameter int PC_W = rv_pipe_pkg::PIPE_PC_W,
  parameter int INSTR_W = rv_pipe_pkg::PIPE_INSTR_W,
  parameter int TAG_W = rv_pipe_pkg::PIPE_TAG_W,
  parameter bit SKID_EN = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(rv_pipe_pkg::NOP_INSTR)
)(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               up_valid_i,
  output logic               up_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               dn_valid_o,
  input  logic               dn_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [TAG_W-1:0]   tag_o
);
  import rv_pipe_pkg::ST_EMPTY, rv_pipe_pkg::ST_ONE, rv_pipe_pkg::ST_FULL;
  logic [1:0] state, state_n;
  logic up_fire, dn_fire, full, main_ld;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [TAG_W-1:0] main_tag, skid_tag;
  assign full = state == ST_FULL;
  assign dn_valid_o = state != ST_EMPTY;
  // reset gating keeps ready low while the async clear is held
  assign up_ready_o = !rst_i & (SKID_EN ? !full : (!dn_valid_o | dn_ready_i));
  assign up_fire = up_valid_i & up_ready_o;
  assign dn_fire = dn_valid_o & dn_ready_i;
  assign state_n = flush_i ? ST_EMPTY
                 : full ? (dn_fire ? ST_ONE : ST_FULL)
                 : up_fire ? ((dn_valid_o & !dn_fire) ? ST_FULL : ST_ONE)
                 : dn_fire ? ST_EMPTY : state;
  assign main_ld = !flush_i & (full ? dn_fire : up_fire & (!dn_valid_o | dn_fire));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= ST_EMPTY;
    else state <= state_n;
  pipe_slot_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TAG_W(TAG_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .load(main_ld),
    .pc_d(full ? skid_pc : pc_i),
    .instr_d(full ? skid_instr : instr_i),
    .tag_d(full ? skid_tag : tag_i),
    .pc_q(main_pc), .instr_q(main_instr), .tag_q(main_tag)
  );
  if (SKID_EN) begin : g_skid
    logic skid_ld;
    assign skid_ld = !flush_i & up_fire & dn_valid_o & !dn_fire;
    pipe_slot_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TAG_W(TAG_W), .NOP_INSTR(NOP_INSTR)) u_skid (
      .clk_i(clk_i), .rst_i(rst_i), .load(skid_ld),
      .pc_d(pc_i), .instr_d(instr_i), .tag_d(tag_i),
      .pc_q(skid_pc), .instr_q(skid_instr), .tag_q(skid_tag)
    );
  end else begin : g_flat
    assign skid_pc = pc_i;
    assign skid_instr = instr_i;
    assign skid_tag = tag_i;
  end
  assign pc_o = dn_valid_o ? main_pc : '0;
  assign instr_o = dn_valid_o ? main_instr : NOP_INSTR;
  assign tag_o = dn_valid_o ? main_tag : '0;
endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// tb_pipe_skid_stage_reg: both SKID_EN modes against a queue-based stage model
module tb_pipe_skid_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic [3:0] tag;} pay_t;
  logic clk_i = 0, rst_i = 1, flush_i = 0, dn_ready_i = 0;
  logic vin_s = 0, vin_n = 0, rdy_s, rdy_n, vld_s, vld_n;
  logic [31:0] pci_s = 0, pci_n = 0, ini_s = 0, ini_n = 0, pc_s, pc_n, ins_s, ins_n;
  logic [3:0] tgi_s = 0, tgi_n = 0, tag_s, tag_n;
  pay_t q_s[$], q_n[$], src_s[$], src_n[$];
  logic [31:0] seen_s[$], seen_n[$];
  int n_tests = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  pipe_skid_stage_reg #(.SKID_EN(1)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .up_valid_i(vin_s), .up_ready_o(rdy_s),
    .pc_i(pci_s), .instr_i(ini_s), .tag_i(tgi_s), .dn_valid_o(vld_s), .dn_ready_i(dn_ready_i),
    .pc_o(pc_s), .instr_o(ins_s), .tag_o(tag_s)
  );
  pipe_skid_stage_reg #(.SKID_EN(0)) u_flat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .up_valid_i(vin_n), .up_ready_o(rdy_n),
    .pc_i(pci_n), .instr_i(ini_n), .tag_i(tgi_n), .dn_valid_o(vld_n), .dn_ready_i(dn_ready_i),
    .pc_o(pc_n), .instr_o(ins_n), .tag_o(tag_n)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_src(input logic [31:0] pc, input logic [31:0] ins, input logic [3:0] tg);
    src_s.push_back('{pc, ins, tg});
    src_n.push_back('{pc, ins, tg});
  endtask
  task automatic idle_reset_checks(input string tag);
    check({tag, " s_rdy"}, 32'(rdy_s), 0);
    check({tag, " s_vld"}, 32'(vld_s), 0);
    check({tag, " s_pc"}, pc_s, 0);
    check({tag, " s_ins"}, ins_s, NOP);
    check({tag, " s_tag"}, 32'(tag_s), 0);
    check({tag, " n_rdy"}, 32'(rdy_n), 0);
    check({tag, " n_vld"}, 32'(vld_n), 0);
    check({tag, " n_ins"}, ins_n, NOP);
  endtask
  // one clock: drive at the falling edge, check the model, then apply the edge to the model
  task automatic cyc(input logic go, input logic r, input logic f);
    bit ms_rdy, mn_rdy, us, un, ds, dn;
    vin_s = go && src_s.size() > 0;
    vin_n = go && src_n.size() > 0;
    if (src_s.size() > 0) {pci_s, ini_s, tgi_s} = src_s[0];
    if (src_n.size() > 0) {pci_n, ini_n, tgi_n} = src_n[0];
    dn_ready_i = r;
    flush_i = f;
    #1;
    ms_rdy = q_s.size() < 2;
    mn_rdy = q_n.size() == 0 || r;
    check("s_rdy", 32'(rdy_s), 32'(ms_rdy));
    check("s_vld", 32'(vld_s), 32'(q_s.size() > 0));
    check("s_pc", pc_s, q_s.size() > 0 ? q_s[0].pc : 32'h0);
    check("s_ins", ins_s, q_s.size() > 0 ? q_s[0].instr : NOP);
    check("s_tag", 32'(tag_s), q_s.size() > 0 ? 32'(q_s[0].tag) : 32'h0);
    check("n_rdy", 32'(rdy_n), 32'(mn_rdy));
    check("n_vld", 32'(vld_n), 32'(q_n.size() > 0));
    check("n_pc", pc_n, q_n.size() > 0 ? q_n[0].pc : 32'h0);
    check("n_ins", ins_n, q_n.size() > 0 ? q_n[0].instr : NOP);
    check("n_tag", 32'(tag_n), q_n.size() > 0 ? 32'(q_n[0].tag) : 32'h0);
    if (vld_s && r) seen_s.push_back(pc_s);
    if (vld_n && r) seen_n.push_back(pc_n);
    us = vin_s && ms_rdy;
    un = vin_n && mn_rdy;
    ds = q_s.size() > 0 && r;
    dn = q_n.size() > 0 && r;
    @(posedge clk_i);
    if (ds) void'(q_s.pop_front());
    if (dn) void'(q_n.pop_front());
    if (us) begin
      if (!f) q_s.push_back(src_s[0]);
      void'(src_s.pop_front());
    end
    if (un) begin
      if (!f) q_n.push_back(src_n[0]);
      void'(src_n.pop_front());
    end
    if (f) begin
      q_s.delete();
      q_n.delete();
    end
    @(negedge clk_i);
  endtask
  initial begin
    #1;
    idle_reset_checks("por");
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    // skid fill/drain
    push_src(32'h10, 32'h0000_0113, 4'h1);
    push_src(32'h14, 32'h0000_0193, 4'h2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #1;
    check("fill s_rdy", 32'(rdy_s), 0);
    check("fill s_pc", pc_s, 32'h10);
    check("fill n_pc", pc_n, 32'h10);
    check("fill n_rdy_lo", 32'(rdy_n), 0);
    dn_ready_i = 1;
    #1;
    check("fill n_rdy_hi", 32'(rdy_n), 1);
    dn_ready_i = 0;
    #1;
    check("fill n_rdy_lo2", 32'(rdy_n), 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    check("drain s_cnt", seen_s.size(), 2);
    check("drain n_cnt", seen_n.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check("drain s_ord", seen_s[i], 32'h10 + 32'(4 * i));
      check("drain n_ord", seen_n[i], 32'h10 + 32'(4 * i));
    end
    // streaming
    seen_s.delete();
    seen_n.delete();
    for (int i = 0; i < 8; i++) push_src(32'h200 + 32'(4 * i), $urandom, 4'($urandom));
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    check("strm s_cnt", seen_s.size(), 8);
    check("strm n_cnt", seen_n.size(), 8);
    for (int i = 0; i < 8; i++) check("strm s_ord", seen_s[i], 32'h200 + 32'(4 * i));
    // flush while FULL with a payload offered
    push_src(32'h30, 32'h0000_0213, 4'h3);
    push_src(32'h34, 32'h0000_0293, 4'h4);
    push_src(32'h40, 32'h0000_0313, 4'h5);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    #1;
    check("flush s_vld", 32'(vld_s), 0);
    check("flush s_ins", ins_s, NOP);
    check("flush s_pc", pc_s, 0);
    check("flush s_rdy", 32'(rdy_s), 1);
    check("flush n_vld", 32'(vld_n), 0);
    cyc(1, 0, 1);
    #1;
    check("flush_acc s_vld", 32'(vld_s), 0);
    check("flush_acc n_vld", 32'(vld_n), 0);
    src_s.delete();
    src_n.delete();
    cyc(0, 1, 0);
    // randomised valid/ready/flush
    for (int i = 0; i < 1000; i++) begin
      if (src_s.size() < 4) src_s.push_back('{32'($urandom) & ~32'h3, 32'($urandom), 4'($urandom)});
      if (src_n.size() < 4) src_n.push_back('{32'($urandom) & ~32'h3, 32'($urandom), 4'($urandom)});
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    src_s.delete();
    src_n.delete();
    cyc(0, 1, 1);
    // async reset while FULL
    push_src(32'h50, 32'h0000_0393, 4'h6);
    push_src(32'h54, 32'h0000_0413, 4'h7);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    src_s.delete();
    src_n.delete();
    vin_s = 0;
    vin_n = 0;
    #2 rst_i = 1;
    #1;
    idle_reset_checks("rst");
    q_s.delete();
    q_n.delete();
    @(negedge clk_i);
    rst_i = 0;
    push_src(32'h100, 32'h0050_0093, 4'h0);
    cyc(1, 0, 0);
    #1;
    check("post_rst s_pc", pc_s, 32'h100);
    check("post_rst s_ins", ins_s, 32'h0050_0093);
    check("post_rst s_vld", 32'(vld_s), 1);
    check("post_rst n_pc", pc_n, 32'h100);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
